// File: rtl/param_down_counter.sv
// Registered down counter with variable step, underflow pulse, sticky status and zero flag.
// Optional reload-on-borrow timer behaviour is enabled by defining PARAM_DOWN_COUNTER_RELOAD_EN.
module param_down_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned STEP_W   = 4,
   parameter bit          SATURATE = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              dec_en,
   input  logic [STEP_W-1:0] step,
   input  logic              clr_sticky,
   output logic [WIDTH-1:0]  count,
   output logic              underflow,
   output logic              uflow_sticky,
   output logic              zero
);

   if (WIDTH < 2 || STEP_W < 1 || STEP_W > WIDTH) begin : g_param_check
      $error("param_down_counter: illegal WIDTH/STEP_W combination");
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic             underflow_q, underflow_d;
   logic             sticky_q, sticky_d;
   logic [WIDTH-1:0] step_ext;
   logic [WIDTH:0]   diff;
   logic             borrow;
   logic [WIDTH-1:0] borrow_val;

   assign step_ext = WIDTH'(step);
   assign diff     = {1'b0, count_q} - {1'b0, step_ext};
   assign borrow   = diff[WIDTH];

`ifdef PARAM_DOWN_COUNTER_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;

   always_comb begin
      reload_d = reload_q;
      if (load) begin
         reload_d = load_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end

   // On borrow the count restarts from the last loaded value regardless of SATURATE.
   assign borrow_val = reload_q;
`else
   always_comb begin
      borrow_val = diff[WIDTH-1:0];
      if (SATURATE) begin
         borrow_val = '0;
      end
   end
`endif

   always_comb begin
      count_d     = count_q;
      underflow_d = 1'b0;
      if (load) begin
         count_d = load_val;
      end else if (dec_en) begin
         if (borrow) begin
            count_d     = borrow_val;
            underflow_d = 1'b1;
         end else begin
            count_d = diff[WIDTH-1:0];
         end
      end
   end

   // A new underflow takes precedence over a simultaneous clear request.
   always_comb begin
      sticky_d = sticky_q;
      if (underflow_d) begin
         sticky_d = 1'b1;
      end else if (clr_sticky) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         underflow_q <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         count_q     <= count_d;
         underflow_q <= underflow_d;
         sticky_q    <= sticky_d;
      end
   end

   assign count        = count_q;
   assign underflow    = underflow_q;
   assign uflow_sticky = sticky_q;
   assign zero         = (count_q == '0);

endmodule

// File: tb/tb_param_down_counter.sv
// Scoreboard bench driving a wrapping (WIDTH=4, STEP_W=4) and a saturating (WIDTH=4, STEP_W=2)
// counter from shared stimulus; expectations come from an integer reference model.
module tb_param_down_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [3:0] load_val;
   logic       dec_en;
   logic [3:0] step;
   logic       clr_sticky;

   logic [3:0] cnt_w, cnt_s;
   logic       uf_w, uf_s, st_w, st_s, z_w, z_s;

   always #5 clk = ~clk;

   param_down_counter #(.WIDTH(4), .STEP_W(4), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dec_en(dec_en),
      .step(step), .clr_sticky(clr_sticky), .count(cnt_w), .underflow(uf_w),
      .uflow_sticky(st_w), .zero(z_w)
   );

   param_down_counter #(.WIDTH(4), .STEP_W(2), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dec_en(dec_en),
      .step(step[1:0]), .clr_sticky(clr_sticky), .count(cnt_s), .underflow(uf_s),
      .uflow_sticky(st_s), .zero(z_s)
   );

   typedef struct {
      logic [3:0] cnt;
      logic       uf;
      logic       stk;
   } exp_t;

   exp_t q_w[$];
   exp_t q_s[$];
   int   checks = 0;
   int   errors = 0;

   int m_cnt[2];
   int m_rl[2];
   bit m_uf[2];
   bit m_stk[2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0;
         m_rl[i]  = 0;
         m_uf[i]  = 1'b0;
         m_stk[i] = 1'b0;
      end
   endtask

   // Apply one edge worth of stimulus and queue the expected post-edge state.
   task automatic drive(input bit ld, input logic [3:0] lv, input bit de,
                        input logic [3:0] st, input bit clr);
      @(negedge clk);
      load = ld; load_val = lv; dec_en = de; step = st; clr_sticky = clr;
      for (int i = 0; i < 2; i++) begin
         int s;
         int d;
         s = (i == 0) ? int'(st) : int'(st[1:0]);
         if (ld) begin
            m_cnt[i] = int'(lv);
            m_rl[i]  = int'(lv);
            m_uf[i]  = 1'b0;
         end else if (de) begin
            d = m_cnt[i] - s;
            if (d < 0) begin
               m_uf[i] = 1'b1;
`ifdef PARAM_DOWN_COUNTER_RELOAD_EN
               m_cnt[i] = m_rl[i];
`else
               m_cnt[i] = (i == 1) ? 0 : d + 16;
`endif
            end else begin
               m_cnt[i] = d;
               m_uf[i]  = 1'b0;
            end
         end else begin
            m_uf[i] = 1'b0;
         end
         if (m_uf[i]) m_stk[i] = 1'b1;
         else if (clr) m_stk[i] = 1'b0;
      end
      q_w.push_back('{cnt: 4'(m_cnt[0]), uf: m_uf[0], stk: m_stk[0]});
      q_s.push_back('{cnt: 4'(m_cnt[1]), uf: m_uf[1], stk: m_stk[1]});
   endtask

   always @(posedge clk) begin : scoreboard
      exp_t e;
      #1;
      if (q_w.size() > 0) begin
         e = q_w.pop_front();
         checks++;
         if ({cnt_w, uf_w, st_w, z_w} !== {e.cnt, e.uf, e.stk, (e.cnt == 4'd0)}) begin
            errors++;
            $display("FAIL wrap_edge t=%0t got cnt=%0d uf=%b stk=%b z=%b exp cnt=%0d uf=%b stk=%b z=%b",
                     $time, cnt_w, uf_w, st_w, z_w, e.cnt, e.uf, e.stk, (e.cnt == 4'd0));
         end
      end
      if (q_s.size() > 0) begin
         e = q_s.pop_front();
         checks++;
         if ({cnt_s, uf_s, st_s, z_s} !== {e.cnt, e.uf, e.stk, (e.cnt == 4'd0)}) begin
            errors++;
            $display("FAIL sat_edge t=%0t got cnt=%0d uf=%b stk=%b z=%b exp cnt=%0d uf=%b stk=%b z=%b",
                     $time, cnt_s, uf_s, st_s, z_s, e.cnt, e.uf, e.stk, (e.cnt == 4'd0));
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; load_val = '0; dec_en = 1'b0; step = '0; clr_sticky = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({cnt_w, uf_w, st_w, z_w} !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_wrap got %b exp 0000001", {cnt_w, uf_w, st_w, z_w});
      end
      checks++;
      if ({cnt_s, uf_s, st_s, z_s} !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_sat got %b exp 0000001", {cnt_s, uf_s, st_s, z_s});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic_dec();
      drive(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
      repeat (3) drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
   endtask

   task automatic test_wrap();
      drive(1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_saturate();
      drive(1'b1, 4'd2, 1'b0, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd3, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
   endtask

   task automatic test_priority_sticky();
      drive(1'b1, 4'd9, 1'b1, 4'd2, 1'b0);
      drive(1'b1, 4'd1, 1'b0, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd2, 1'b1);
      drive(1'b0, 4'd0, 1'b1, 4'd0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 4'd8, 1'b0, 4'd0, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd15, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      dec_en = 1'b0;
      model_reset();
      #1;
      checks++;
      if ({cnt_w, uf_w, st_w, z_w} !== 7'b0000001) begin
         errors++;
         $display("FAIL async_reset_wrap got %b exp 0000001", {cnt_w, uf_w, st_w, z_w});
      end
      checks++;
      if ({cnt_s, uf_s, st_s, z_s} !== 7'b0000001) begin
         errors++;
         $display("FAIL async_reset_sat got %b exp 0000001", {cnt_s, uf_s, st_s, z_s});
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_reload();
      drive(1'b1, 4'd3, 1'b0, 4'd0, 1'b0);
      repeat (8) drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         drive(($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
               4'($urandom), ($urandom_range(0, 5) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_basic_dec();
      test_wrap();
      test_saturate();
      test_priority_sticky();
      test_reset_mid();
      test_reload();
      test_random();
      @(negedge clk);
      load = 1'b0; dec_en = 1'b0; clr_sticky = 1'b0;
      for (int i = 0; i < 10 && (q_w.size() > 0 || q_s.size() > 0); i++) @(posedge clk);
      #2;
      checks++;
      if (q_w.size() > 0 || q_s.size() > 0) begin
         errors++;
         $display("FAIL drain got %0d pending exp 0", q_w.size() + q_s.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
